// File: rtl/neuron_scheduler.sv
// neuron_scheduler: time-multiplexes NUM neuron states onto one external
// neuron core. Each timestep sweep walks every neuron through
// LOAD (preset core) -> STEP (one update) -> STORE (writeback), then DONE.
// Optional build macro NEURON_SPIKE_COUNT_EN adds per-neuron 16-bit
// saturating spike counters readable via cnt_addr/cnt_data.
module neuron_scheduler #(
  parameter int          N      = 32,
  parameter int          Q      = 16,
  parameter int          NUM    = 8,
  parameter logic [N-1:0] V_REST = 32'hFFBF0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic [NUM*N-1:0]        i_bus,
  input  logic [N-1:0]            v_th,
  input  logic                    init_we,
  input  logic [$clog2(NUM)-1:0]  init_addr,
  input  logic [N-1:0]            init_v,
  input  logic [N-1:0]            init_w,
  output logic [NUM-1:0]          spikes,
  output logic                    core_rst,
  output logic                    core_apply,
  output logic [N-1:0]            core_v_init,
  output logic [N-1:0]            core_w_init,
  output logic [N-1:0]            core_i,
  input  logic [N-1:0]            core_voltage,
  input  logic [N-1:0]            core_w,
  input  logic [$clog2(NUM)-1:0]  cnt_addr,
  output logic [15:0]             cnt_data
);

  localparam int AW = $clog2(NUM);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // The scheduler never does arithmetic on voltages, so the fraction width
  // only matters for sanity: a sign bit must remain above the fraction.
  generate
    if (Q >= N) begin : g_fraction_too_wide
      // Intentionally empty: such a format has no sign bit and the signed
      // threshold compare would be meaningless.
    end
  endgenerate

  logic [2:0]     state;
  logic [AW-1:0]  idx;
  logic [N-1:0]   v_mem [NUM];
  logic [N-1:0]   w_mem [NUM];
  logic [NUM-1:0] spk_acc;
  logic           spike_now;

  // Spike decision uses the voltage the neuron entered this step with.
  assign spike_now = $signed(v_mem[idx]) > $signed(v_th);

  // Core handshake: reset strobe in LOAD, update strobe in STEP, never both.
  assign busy        = (state != S_IDLE);
  assign core_rst    = (state == S_LOAD);
  assign core_apply  = (state == S_STEP);
  assign core_v_init = v_mem[idx];
  assign core_w_init = w_mem[idx];
  assign core_i      = i_bus[idx*N +: N];

  // Sweep FSM, state memories, spike vector and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      done    <= 1'b0;
      spikes  <= '0;
      spk_acc <= '0;
      for (int k = 0; k < NUM; k++) begin
        v_mem[k] <= V_REST;
        w_mem[k] <= '0;
      end
    end else begin
      // done rises the cycle after DONE, alongside the spikes update
      done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (init_we) begin
            v_mem[init_addr] <= init_v;
            w_mem[init_addr] <= init_w;
          end
          if (start) begin
            state <= S_LOAD;
            idx   <= '0;
          end
        end
        S_LOAD:  state <= S_STEP;
        S_STEP:  state <= S_STORE;
        S_STORE: begin
          v_mem[idx]   <= core_voltage;
          w_mem[idx]   <= core_w;
          spk_acc[idx] <= spike_now;
          if (idx == AW'(NUM - 1)) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          spikes <= spk_acc;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef NEURON_SPIKE_COUNT_EN
  logic [15:0] cnt [NUM];

  // Per-neuron saturating spike counters, bumped at writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM; k++) cnt[k] <= '0;
    end else if (state == S_STORE && spike_now && cnt[idx] != 16'hFFFF) begin
      cnt[idx] <= cnt[idx] + 16'd1;
    end
  end

  assign cnt_data = cnt[cnt_addr];
`else
  logic cnt_addr_unused;
  assign cnt_addr_unused = ^cnt_addr;
  assign cnt_data        = '0;
`endif

endmodule

// File: tb/tb_neuron_scheduler.sv
// Directed bench for neuron_scheduler with a behavioural stub core.
module tb_neuron_scheduler;
  localparam int N   = 32;
  localparam int NUM = 8;
  localparam logic [31:0] V_REST = 32'hFFBF0000;
  localparam logic [31:0] TH_30  = 32'h001E0000;
  localparam logic [31:0] TH_M70 = 32'hFFBA0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy, done;
  logic [NUM*N-1:0] i_bus;
  logic [N-1:0]     v_th;
  logic             init_we;
  logic [2:0]       init_addr;
  logic [N-1:0]     init_v, init_w;
  logic [NUM-1:0]   spikes;
  logic             core_rst, core_apply;
  logic [N-1:0]     core_v_init, core_w_init, core_i;
  logic [N-1:0]     core_voltage, core_w;
  logic [2:0]       cnt_addr;
  logic [15:0]      cnt_data;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] v_seen [NUM];
  logic         busy_first;
  logic         busy_at_done;
  logic         add_i;
  logic [N-1:0] sv = '0;
  logic [N-1:0] sw = '0;

  always #5 clk = ~clk;

  neuron_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .i_bus(i_bus), .v_th(v_th), .init_we(init_we), .init_addr(init_addr),
    .init_v(init_v), .init_w(init_w), .spikes(spikes),
    .core_rst(core_rst), .core_apply(core_apply),
    .core_v_init(core_v_init), .core_w_init(core_w_init), .core_i(core_i),
    .core_voltage(core_voltage), .core_w(core_w),
    .cnt_addr(cnt_addr), .cnt_data(cnt_data)
  );

  // stub core: preset on core_rst, add input current on core_apply if enabled
  always @(posedge clk) begin
    if (core_rst) begin
      sv <= core_v_init;
      sw <= core_w_init;
    end else if (core_apply) begin
      sv <= sv + (add_i ? core_i : '0);
    end
  end
  assign core_voltage = sv;
  assign core_w       = sw;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Caller sits at a negedge. Returns at the negedge where done is high
  // (done_t = cycles after the accept edge) or after the budget (-1).
  task automatic run_sweep(output int done_t, output int pat_err);
    logic exp_r, exp_a;
    done_t  = -1;
    pat_err = 0;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    init_we = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (t == 0) busy_first = busy;
      if (done) begin
        done_t       = t;
        busy_at_done = busy;
        break;
      end
      exp_r = (t < 3*NUM) && (t % 3 == 0);
      exp_a = (t < 3*NUM) && (t % 3 == 1);
      if (core_rst !== exp_r || core_apply !== exp_a) pat_err++;
      if (core_rst) v_seen[t/3] = core_v_init;
    end
  endtask

  task automatic preload(input int a, input logic [N-1:0] v);
    init_addr = 3'(a);
    init_v    = v;
    init_w    = '0;
    init_we   = 1'b1;
    @(negedge clk);
    init_we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dt, pe, nd;
    rst = 1'b1; start = 1'b0; init_we = 1'b0; init_addr = '0;
    init_v = '0; init_w = '0; v_th = TH_30; cnt_addr = '0; add_i = 1'b0;
    i_bus = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_spikes", spikes, 0);
    chk("rst_core_rst", core_rst, 0);
    chk("rst_core_apply", core_apply, 0);
    rst = 1'b0;
    @(negedge clk);

    // timing and strobe pattern, identity core, then back-to-back sweep
    for (int k = 0; k < NUM; k++) i_bus[k*N +: N] = 32'(k) << 16;
    run_sweep(dt, pe);
    chk("busy_after_accept", busy_first, 1);
    chk("done_latency", dt, 25);
    chk("strobe_pattern", pe, 0);
    chk("busy_at_done", busy_at_done, 0);
    chk("spikes_signed", spikes, 8'h00);
    run_sweep(dt, pe);
    chk("b2b_latency", dt, 25);
    for (int k = 0; k < NUM; k++) chk($sformatf("vrest_%0d", k), v_seen[k], V_REST);
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    // threshold: equal is not a spike, just above is
    preload(3, 32'h001E0000);
    run_sweep(dt, pe);
    chk("spike_equal", spikes, 8'h00);
    @(negedge clk);
    preload(3, 32'h001E8000);
    run_sweep(dt, pe);
    chk("spike_above", spikes, 8'b0000_1000);
    repeat (5) @(negedge clk);
    chk("spikes_stable", spikes, 8'b0000_1000);

    // negative threshold: every neuron above it
    v_th = TH_M70;
    run_sweep(dt, pe);
    chk("spike_neg_th", spikes, 8'hFF);
    @(negedge clk);

    // init and start in the same idle cycle: sweep sees the written value
    init_addr = 3'd2; init_v = 32'h00050000; init_w = '0; init_we = 1'b1;
    run_sweep(dt, pe);
    chk("init_then_start", v_seen[2], 32'h00050000);
    @(negedge clk);

    // writeback through the mux: two accumulating sweeps, observe in a third
    do_reset();
    v_th  = TH_30;
    add_i = 1'b1;
    run_sweep(dt, pe);
    run_sweep(dt, pe);
    run_sweep(dt, pe);
    for (int k = 0; k < NUM; k++)
      chk($sformatf("wb_v_%0d", k), v_seen[k], 32'(V_REST + (32'(2*k) << 16)));
    @(negedge clk);

    // abort in STEP of neuron 5
    do_reset();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    repeat (16) @(negedge clk);
    chk("abort_in_step", core_apply, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_core_rst", core_rst, 0);
    chk("abort_core_apply", core_apply, 0);
    chk("abort_spikes", spikes, 0);
    nd = 0;
    for (int t = 0; t < 40; t++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("abort_no_done", nd, 0);
    add_i = 1'b0;
    run_sweep(dt, pe);
    for (int k = 0; k < 5; k++) chk($sformatf("abort_v_%0d", k), v_seen[k], V_REST);
    @(negedge clk);

    // spike counters
    do_reset();
    v_th = TH_M70;
    run_sweep(dt, pe);
    run_sweep(dt, pe);
    run_sweep(dt, pe);
    @(negedge clk);
    cnt_addr = 3'd0;
    #1;
`ifdef NEURON_SPIKE_COUNT_EN
    chk("cnt_n0", cnt_data, 16'd3);
`else
    chk("cnt_n0", cnt_data, 16'd0);
`endif
    cnt_addr = 3'd5;
    #1;
`ifdef NEURON_SPIKE_COUNT_EN
    chk("cnt_n5", cnt_data, 16'd3);
`else
    chk("cnt_n5", cnt_data, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/neuron_scheduler.md
NEURON_SCHEDULER -- requirements
Module: neuron_scheduler

Interface
REQ-001 SHALL have parameters: N, 32, word width; Q, 16, fraction bits (signed fixed point); NUM, 8, neurons multiplexed onto one core (power of two, 2..64); V_REST, 32'hFFBF0000, reset voltage (-65.0).
REQ-002 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-003 SHALL have ports: start in 1, begin one timestep sweep; busy out 1, sweep in progress; done out 1, one-cycle sweep-complete pulse.
REQ-004 SHALL have ports: i_bus in NUM*N, per-neuron input currents, slice k = neuron k; v_th in N, spike threshold.
REQ-005 SHALL have ports: init_we in 1; init_addr in log2(NUM); init_v in N; init_w in N; state preload.
REQ-006 SHALL have ports: spikes out NUM, spike flags of last completed sweep.
REQ-007 SHALL have core-side ports: core_rst out 1; core_apply out 1; core_v_init out N; core_w_init out N; core_i out N; core_voltage in N; core_w in N.
REQ-008 SHALL have ports: cnt_addr in log2(NUM); cnt_data out 16, spike count readback.

Function
REQ-009 SHALL hold per-neuron state arrays v_mem[NUM], w_mem[NUM] of N bits and an index register idx.
REQ-010 SHALL implement states IDLE, LOAD, STEP, STORE, DONE.
REQ-011 IDLE: busy=0; start=1 at an edge -> LOAD, idx=0, busy=1 from next cycle.
REQ-012 LOAD: core_rst=1, core_v_init=v_mem[idx], core_w_init=w_mem[idx], core_i=i_bus slice idx; -> STEP.
REQ-013 STEP: core_apply=1, core_rst=0, core_i held; -> STORE.
REQ-014 STORE: v_mem[idx]<=core_voltage, w_mem[idx]<=core_w; spike bit idx of internal vector <= ($signed(v_mem[idx]) > $signed(v_th)) using pre-update value; idx==NUM-1 -> DONE, else idx+1 and -> LOAD.
REQ-015 DONE: done=1 for exactly one cycle, spikes<=internal vector at that edge, -> IDLE.
REQ-016 Sweep latency SHALL be 3*NUM+1 cycles from start-accept edge to done high; back-to-back start in the cycle after done SHALL be accepted.
REQ-017 core_rst and core_apply SHALL never be high in the same cycle; both 0 outside LOAD/STEP.
REQ-018 start while busy SHALL be ignored (no queueing).
REQ-019 init_we in IDLE SHALL write v_mem/w_mem[init_addr] at the edge; init_we while busy SHALL be ignored; init_we and start in the same IDLE cycle: write occurs, then sweep starts using written value.
REQ-020 Comparison SHALL be signed, strictly greater; v equal to v_th is not a spike.
REQ-021 spikes SHALL stay stable between DONE states.

Reset
REQ-022 rst SHALL take priority over all inputs, including mid-sweep: state IDLE, idx=0, busy=0, done=0, spikes=0, core_rst=0, core_apply=0.
REQ-023 rst SHALL set every v_mem to V_REST and every w_mem to 0; an aborted sweep leaves no partial writeback after rst.

Configuration
REQ-024 Macro NEURON_SPIKE_COUNT_EN SHALL select per-neuron 16-bit spike counters.
REQ-025 Defined: counter k increments in STORE when neuron k spikes, saturates at 16'hFFFF, cleared by rst; cnt_data=counter[cnt_addr] combinationally.
REQ-026 Undefined: no counters synthesized, cnt_data tied to 0.

Verification
REQ-027 Reset: assert rst 2 cycles -> busy=0, done=0, spikes=0; sweep with stub core returning inputs unchanged leaves all v_mem at 32'hFFBF0000.
REQ-028 Timing: NUM=8, start 1 cycle -> busy high next cycle, done high exactly 25 cycles after accept edge for one cycle; core_rst/core_apply pattern 1,0 / 0,1 / 0,0 repeated 8 times.
REQ-029 Spike: preload neuron 3 v=30.0 (32'h001E0000), v_th=30.0 -> no spike; preload 30.5 (32'h001E8000) -> spikes=8'b0000_1000 after done.
REQ-030 Writeback/mux: stub core voltage=v_init+i; i_bus slice k=k*1.0, two sweeps -> v_mem[k]=-65.0+2k, verified via core_v_init in third sweep.
REQ-031 Abort: rst asserted in STEP of neuron 5 -> IDLE next cycle, done never pulses, v_mem[0..4] back to V_REST.
REQ-032 Counters (NEURON_SPIKE_COUNT_EN): neuron 0 spikes in 3 sweeps -> cnt_addr=0 gives 3; without macro cnt_data=0.
